mmio_slave_router: RTL
======================

Name: mmio_slave_router

Overview:
- Parametrised successor to the fixed MMIO address map: a single-master, N-slave request router for the SoC peripheral network.
- Device count and address windows are parameters instead of hard-coded entries.
- Adds behaviour the fixed map lacks:
  - decode-error responses for unmapped addresses;
  - per-transaction response timeout;
  - a per-slave "stale" lock-out after a timeout.
- Sits between the CPU load/store unit MMIO path and the peripheral slaves (UART, timer, GPIO, SPI, Ethernet, PRNG, memories).

Parameters:
- SLAVES, 8, number of routed devices (1..32).
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width.
- LOW_ADDRESS, per-slave int array, inclusive window base.
- HIGH_ADDRESS, per-slave int array, inclusive window top.
- TIMEOUT_CYCLES, 1024, WAIT-state cycle limit; 0 disables the timeout.
- ERROR_DATA, 32'hDEAD_BEEF, read data returned on any error.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- req_valid_i  in  1  master request valid
- req_ready_o  out  1  router idle, can accept
- req_write_i  in  1  1=write, 0=read
- req_address_i  in  ADDR_WIDTH  request address
- req_data_i  in  DATA_WIDTH  write data
- resp_valid_o  out  1  one-cycle response pulse
- resp_data_o  out  DATA_WIDTH  read data
- resp_error_o  out  1  decode, timeout or slave error
- slv_valid_o  out  SLAVES  one-hot request strobe
- slv_write_o  out  1  registered write flag
- slv_address_o  out  ADDR_WIDTH  registered address
- slv_data_o  out  DATA_WIDTH  registered write data
- slv_resp_valid_i  in  SLAVES  per-slave response valid
- slv_resp_data_i  in  SLAVES*DATA_WIDTH  per-slave read data, packed, slave 0 in LSBs
- slv_resp_error_i  in  SLAVES  per-slave error, sampled with resp valid
- stale_o  out  SLAVES  per-slave stale flags, for debug/CSR

Behaviour:
- Clock and reset: one clock (clk_i); reset (rst_i) is synchronous and active high.
- Reset values:
  - state=IDLE, req_ready_o=1;
  - resp_valid_o=0, resp_error_o=0, resp_data_o=0;
  - slv_valid_o=0, slv_write_o=0, slv_address_o=0, slv_data_o=0;
  - stale_o=0, timeout counter=0.
- Reset mid-transaction: abandons it, with no response. Slave responses arriving later are ignored, because no slave is selected in IDLE.
- Only one transaction is outstanding at a time.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i && req_ready_o, register address, data and write flag, then go to DECODE.
- DECODE:
  - Slave i matches if LOW_ADDRESS[i] <= addr <= HIGH_ADDRESS[i] (unsigned compare).
  - If several slaves match, the lowest index wins.
  - No match -> RESPOND with error=1, data=ERROR_DATA.
  - Match on a slave with stale set -> RESPOND with error=1, data=ERROR_DATA, without touching the slave.
  - Otherwise -> ISSUE.
- ISSUE: slv_valid_o[sel]=1 for exactly one cycle, clear the counter, go to WAIT.
- WAIT:
  - On slv_resp_valid_i[sel]: capture data and error, go to RESPOND.
  - Responses from non-selected slaves are ignored.
  - Otherwise the counter increments.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without a response, set stale[sel] and go to RESPOND with error=1, data=ERROR_DATA.
- RESPOND: resp_valid_o=1 for one cycle, then IDLE.
- resp_data_o and resp_error_o are held until the next RESPOND. Writes return data 0 on success.
- Latency: accept at edge N, then:
  - decode error: resp_valid_o high in cycle N+2;
  - slave responding in its first WAIT cycle: slv_valid_o high in N+2, resp_valid_o high in N+4.
- Stale clear: stale[i] clears on any cycle where slv_resp_valid_i[i]=1 while slave i is not the current WAIT target. This drains the late response.
- Simultaneous timeout and response on the same cycle: the response wins and stale is not set.
- Counter width: $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

Decomposition:
- Add to soc_parameters:
  - router_state_t enum (IDLE, DECODE, ISSUE, WAIT, RESPOND);
  - ROUTER_TIMEOUT_CYCLES and ROUTER_ERROR_DATA;
  - existing LOW/HIGH_SLAVE_ADDRESS arrays passed as LOW_ADDRESS/HIGH_ADDRESS.
- One sub-module, mmio_address_decoder: combinational window compare plus a priority encoder, producing a hit flag and index of width $clog2(SLAVES).

Test Plan:
- SLAVES=2, windows 0x1000-0x100F and 0x2000-0x200F; read 0x2004, slave 1 returns 0x1234_5678 after 3 cycles -> slv_valid_o=2'b10 for one cycle, resp_data_o=0x1234_5678, resp_error_o=0.
- Read 0x3000 (unmapped) -> no slv_valid_o pulse, resp_valid_o 2 cycles after accept, error=1, data=0xDEAD_BEEF.
- Overlapping windows, slave 0 = 0x0-0xFF and slave 1 = 0x80-0x17F; write 0x90 -> only slave 0 strobed.
- TIMEOUT_CYCLES=4, slave 0 silent -> error response, stale_o[0]=1; next request to slave 0 -> immediate error with no strobe; slave 0 late resp_valid -> stale_o[0]=0; following request is strobed normally.
- Assert rst_i during WAIT, then slave responds -> no resp_valid_o, req_ready_o=1, all outputs at reset values.
- Slave response and timeout expiry on the same cycle -> resp_error_o equals the slave's error bit, stale_o unchanged.

Source files
------------

// File: rtl/mmio_slave_router_pkg.sv
// Shared definitions for the MMIO slave router: FSM state type, router defaults
// and the default SoC peripheral address map.
package mmio_slave_router_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    RESPOND = 3'd4
  } router_state_t;

  localparam int unsigned ROUTER_TIMEOUT_CYCLES = 1024;
  localparam logic [31:0] ROUTER_ERROR_DATA     = 32'hDEAD_BEEF;

  // Default map: UART, timer, GPIO, SPI, Ethernet, PRNG, ROM, RAM
  localparam int unsigned LOW_SLAVE_ADDRESS [8] = '{
    32'h1000_0000, 32'h1000_1000, 32'h1000_2000, 32'h1000_3000,
    32'h1001_0000, 32'h1000_4000, 32'h0000_0000, 32'h8000_0000
  };
  localparam int unsigned HIGH_SLAVE_ADDRESS [8] = '{
    32'h1000_0FFF, 32'h1000_1FFF, 32'h1000_2FFF, 32'h1000_3FFF,
    32'h1001_FFFF, 32'h1000_4FFF, 32'h0000_FFFF, 32'h8FFF_FFFF
  };

endpackage

// File: rtl/mmio_slave_router_decoder.sv
// Combinational address-window compare with a lowest-index-wins priority encoder.
module mmio_address_decoder import mmio_slave_router_pkg::*; #(
  parameter int          SLAVES     = 8,
  parameter int          ADDR_WIDTH = 32,
  parameter int          IDX_W      = (SLAVES > 1) ? $clog2(SLAVES) : 1,
  parameter int unsigned LOW_ADDRESS  [SLAVES] = LOW_SLAVE_ADDRESS,
  parameter int unsigned HIGH_ADDRESS [SLAVES] = HIGH_SLAVE_ADDRESS
) (
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  hit,
  output logic [IDX_W-1:0]      index
);

  // Scan from the top so the lowest matching slave is the last writer.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (address >= ADDR_WIDTH'(LOW_ADDRESS[i]) &&
          address <= ADDR_WIDTH'(HIGH_ADDRESS[i])) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_slave_router.sv
// Single-master, N-slave MMIO request router with decode errors, a response
// timeout and a per-slave stale lock-out after a timeout.
module mmio_slave_router import mmio_slave_router_pkg::*; #(
  parameter int                    SLAVES         = 8,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int unsigned           LOW_ADDRESS  [SLAVES] = LOW_SLAVE_ADDRESS,
  parameter int unsigned           HIGH_ADDRESS [SLAVES] = HIGH_SLAVE_ADDRESS,
  parameter int unsigned           TIMEOUT_CYCLES = ROUTER_TIMEOUT_CYCLES,
  parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DATA_WIDTH'(ROUTER_ERROR_DATA)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [ADDR_WIDTH-1:0]        req_address_i,
  input  logic [DATA_WIDTH-1:0]        req_data_i,
  output logic                         resp_valid_o,
  output logic [DATA_WIDTH-1:0]        resp_data_o,
  output logic                         resp_error_o,
  output logic [SLAVES-1:0]            slv_valid_o,
  output logic                         slv_write_o,
  output logic [ADDR_WIDTH-1:0]        slv_address_o,
  output logic [DATA_WIDTH-1:0]        slv_data_o,
  input  logic [SLAVES-1:0]            slv_resp_valid_i,
  input  logic [SLAVES*DATA_WIDTH-1:0] slv_resp_data_i,
  input  logic [SLAVES-1:0]            slv_resp_error_i,
  output logic [SLAVES-1:0]            stale_o
);

  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; resp_valid_o is a one-cycle pulse that needs no
  // acknowledge, and slv_valid_o is a one-cycle strobe the slave must latch.
  router_state_t    state;
  logic [IDX_W-1:0] sel;
  logic [CNT_W-1:0] cnt;

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_index;
  logic                  dec_stale;
  logic [SLAVES-1:0]     dec_onehot;
  logic                  sel_valid;
  logic                  sel_error;
  logic [DATA_WIDTH-1:0] sel_data;

  mmio_address_decoder #(
    .SLAVES       (SLAVES),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .IDX_W        (IDX_W),
    .LOW_ADDRESS  (LOW_ADDRESS),
    .HIGH_ADDRESS (HIGH_ADDRESS)
  ) u_decoder (
    .address (slv_address_o),
    .hit     (dec_hit),
    .index   (dec_index)
  );

  always_comb begin
    dec_stale  = 1'b0;
    dec_onehot = '0;
    sel_valid  = 1'b0;
    sel_error  = 1'b0;
    sel_data   = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (IDX_W'(i) == dec_index) begin
        dec_stale     = stale_o[i];
        dec_onehot[i] = 1'b1;
      end
      if (IDX_W'(i) == sel) begin
        sel_valid = slv_resp_valid_i[i];
        sel_error = slv_resp_error_i[i];
        sel_data  = slv_resp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      sel           <= '0;
      cnt           <= '0;
      req_ready_o   <= 1'b1;
      resp_valid_o  <= 1'b0;
      resp_data_o   <= '0;
      resp_error_o  <= 1'b0;
      slv_valid_o   <= '0;
      slv_write_o   <= 1'b0;
      slv_address_o <= '0;
      slv_data_o    <= '0;
      stale_o       <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      slv_valid_o  <= '0;
      // A response from anyone but the slave we are waiting on drains its stale flag.
      for (int i = 0; i < SLAVES; i++) begin
        if (slv_resp_valid_i[i] && !(state == WAIT && sel == IDX_W'(i)))
          stale_o[i] <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            slv_write_o   <= req_write_i;
            slv_address_o <= req_address_i;
            slv_data_o    <= req_data_i;
            req_ready_o   <= 1'b0;
            state         <= DECODE;
          end
        end
        DECODE: begin
          if (!dec_hit || dec_stale) begin
            resp_valid_o <= 1'b1;
            resp_error_o <= 1'b1;
            resp_data_o  <= ERROR_DATA;
            state        <= RESPOND;
          end else begin
            sel         <= dec_index;
            slv_valid_o <= dec_onehot;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (sel_valid) begin
            resp_valid_o <= 1'b1;
            resp_error_o <= sel_error;
            resp_data_o  <= sel_error ? ERROR_DATA : (slv_write_o ? '0 : sel_data);
            state        <= RESPOND;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            for (int i = 0; i < SLAVES; i++) begin
              if (sel == IDX_W'(i)) stale_o[i] <= 1'b1;
            end
            resp_valid_o <= 1'b1;
            resp_error_o <= 1'b1;
            resp_data_o  <= ERROR_DATA;
            state        <= RESPOND;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESPOND: begin
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
